// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite DMA sequencer and the PPU register decode.
package oam_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_PAGE_REG = 16'h4014;
  localparam logic [15:0] OAM_DATA     = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: stalls the CPU, then copies one 256-byte page
// into OAM as alternating read/write bus cycles.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_PAGE_REG,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA,
  parameter int unsigned NUM_BYTES     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        stall,
  output logic        bus_sel,
  output logic [15:0] dma_addr,
  output logic        dma_read,
  output logic        dma_write,
  output logic [7:0]  dma_wdata,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       parity_q, parity_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DMA_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
    end
  end

  // Outputs decode only from registered state so reset clears them at once.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    parity_d  = ~parity_q;
    stall     = 1'b0;
    bus_sel   = 1'b0;
    dma_addr  = '0;
    dma_read  = 1'b0;
    dma_write = 1'b0;
    dma_wdata = '0;
    busy      = (state_q != DMA_IDLE);

    unique case (state_q)
      DMA_IDLE: begin
        if (cpu_write && cpu_addr == DMA_REG_ADDR) begin
          page_d  = cpu_wdata;
          state_d = DMA_HALT;
        end
      end
      DMA_HALT: begin
        stall   = 1'b1;
        state_d = parity_q ? DMA_ALIGN : DMA_READ;
      end
      DMA_ALIGN: begin
        stall   = 1'b1;
        state_d = DMA_READ;
      end
      DMA_READ: begin
        stall    = 1'b1;
        bus_sel  = 1'b1;
        dma_read = 1'b1;
        dma_addr = {page_q, idx_q};
        state_d  = DMA_WRITE;
      end
      DMA_WRITE: begin
        stall     = 1'b1;
        bus_sel   = 1'b1;
        dma_write = 1'b1;
        dma_addr  = OAM_DATA_ADDR;
        dma_wdata = bus_rdata;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DMA_READ;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Sprite DMA sequencer triggered by a CPU store to the DMA page register. It halts the CPU via its stall input and takes ownership of the CPU memory bus. It then copies 256 bytes from page {page,00..FF} to the OAM data port, one read/write pair per byte. It sits beside the CPU and drives a bus mux that chooses between CPU and DMA address/data/strobes.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer (write data = source page)
OAM_DATA_ADDR, 16'h2004, destination address written once per byte
NUM_BYTES, 256, bytes per transfer (index width = 8)

Ports:
clk  in  1  system clock, one CPU bus cycle per clock
rst  in  1  asynchronous, active-high reset
cpu_addr  in  16  CPU bus address
cpu_write  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
bus_rdata  in  8  memory read data; valid the cycle after a read is issued
stall  out  1  to CPU stall input; high from HALT through last WRITE
bus_sel  out  1  1 = DMA owns addr/data/strobes; 0 = CPU owns them
dma_addr  out  16  DMA bus address
dma_read  out  1  DMA read strobe
dma_write  out  1  DMA write strobe
dma_wdata  out  8  DMA write data
busy  out  1  high in any non-IDLE state

Behaviour:
- Reset: state=IDLE, page=0, idx=0, parity=0. All outputs are 0: stall, bus_sel, dma_read, dma_write, busy, dma_addr=0, dma_wdata=0. Reset is async and forces outputs low immediately, including mid-transfer; the CPU resumes on the next clock.
- parity: a 1-bit flop that toggles every clock out of reset.
- Trigger: in IDLE, cpu_write && cpu_addr==DMA_REG_ADDR latches page=cpu_wdata and goes to HALT. A CPU read of DMA_REG_ADDR never triggers.
- States and transitions:
  - IDLE -> HALT on trigger.
  - HALT (1 cycle): stall=1, bus_sel=0, so the CPU's in-flight cycle completes. Goes to ALIGN if parity==1, else to READ.
  - ALIGN (1 cycle): stall=1, bus_sel=0, no strobes. Goes to READ.
  - READ: stall=1, bus_sel=1, dma_read=1, dma_addr={page,idx}. Goes to WRITE.
  - WRITE: stall=1, bus_sel=1, dma_write=1, dma_addr=OAM_DATA_ADDR, dma_wdata=bus_rdata (combinational pass-through of the data returned for the preceding READ).
    - idx==NUM_BYTES-1: go to IDLE and clear idx.
    - Otherwise: idx+1, go to READ.
- stall, bus_sel and the strobes are decoded from the registered state, so there is no combinational path from cpu_* to outputs.
- Latency: trigger at cycle T; HALT at T+1. Total stall = 1 + ALIGN(0|1) + 512 = 513 or 514 cycles. stall is low in the cycle after the last WRITE.
- Address arithmetic: idx is 8 bits. {page,idx} never carries into page; page FF ends at FFFF with no wrap to 0000 beyond idx.
- Trigger while busy (including a store by the CPU in HALT): ignored; page is unchanged.
- dma_read and dma_write are never high together. Strobes are low whenever bus_sel=0.

Decomposition:
- Enums package additions:
  - typedef dma_state_t {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE}
  - constants DMA_PAGE_REG=16'h4014 and OAM_DATA=16'h2004, shared with the PPU register decode.
- No sub-module: a single FSM plus an 8-bit counter. The CPU/DMA bus mux lives at the top level and is not part of this block.

Test Plan:
- Page 8'h02 written with parity=0 at HALT -> stall high exactly 513 cycles. First read addr 16'h0200, last read 16'h02FF. 256 writes to 16'h2004 carrying mem[0x0200..0x02FF] in order.
- Same trigger one cycle later (parity=1 at HALT) -> one ALIGN cycle with bus_sel=0. Stall high exactly 514 cycles. Data sequence identical.
- CPU read of 16'h4014, and a CPU write to 16'h4015 -> busy, stall and bus_sel stay 0.
- Second write to 16'h4014 (data 8'h05) at byte 100 of a page-02 transfer -> ignored. Transfer completes from page 02 with 256 bytes and unchanged length.
- Page 8'hFF -> last read addr 16'hFFFF, then IDLE. No access to 16'h0000.
- rst pulsed during READ of byte 40 -> stall, bus_sel and strobes drop asynchronously. After release, busy=0 and idx=0. A fresh trigger on page 03 performs a full 256-byte transfer starting at 16'h0300.
